// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller.
//   mc_state_t : controller FSM states (idle / byte sequencing / ready pulse)
//   owner_t    : which requester owns the current access
//   LEN_*      : mem_len encodings; len_bytes() maps them to a byte count
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    localparam logic [2:0] WORD_BYTES = 3'd4;

    // 2'b11 is treated as a word access.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return WORD_BYTES;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for the 8-bit RAM port: walks base+cnt one byte per cycle,
// drives write bytes little-endian, and assembles read bytes into a 32-bit buffer.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 latch base/nbytes/wr/wdata, clear cnt and buffer
//   base, nbytes, wr,     access descriptor captured on start
//   wdata
//   active                controller is in its byte-sequencing state
//   last                  final sequencing cycle (read: cnt==N, write: cnt==N-1)
//   rdata                 assembled read buffer, upper bytes zero for short reads
//   ram_addr/we/dout/din  RAM port
module mem_byte_seq
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [2:0]        nbytes,
    input  logic              wr,
    input  logic [31:0]       wdata,
    input  logic              active,
    output logic              last,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    logic [ADDR_W-1:0] base_q;
    logic [2:0]        n_q;
    logic [2:0]        cnt;
    logic              wr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       byte_buf;
    logic [1:0]        fill_idx;
    logic              drive;

    // RAM read data lags the address by one cycle, so cycle c stores byte c-1.
    assign fill_idx = 2'(cnt - 3'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q   <= '0;
            n_q      <= '0;
            cnt      <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            byte_buf <= '0;
        end else if (start) begin
            base_q   <= base;
            n_q      <= nbytes;
            wr_q     <= wr;
            wdata_q  <= wdata;
            cnt      <= '0;
            byte_buf <= '0;
        end else if (active) begin
            cnt <= cnt + 3'd1;
            if (!wr_q && cnt != 3'd0) begin
                byte_buf[8*fill_idx +: 8] <= ram_din;
            end
        end
    end

    always_comb begin
        drive    = active && (cnt < n_q);
        last     = wr_q ? (cnt == n_q - 3'd1) : (cnt == n_q);
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_dout = '0;
        if (drive) begin
            // Modulo 2^ADDR_W: the add simply wraps.
            ram_addr = base_q + ADDR_W'(cnt);
            ram_we   = wr_q;
            if (wr_q) begin
                ram_dout = wdata_q[8*cnt[1:0] +: 8];
            end
        end
    end

    assign rdata = byte_buf;

endmodule

// File: rtl/mem_ctrl.sv
// Shares one 8-bit synchronous RAM port between instruction fetch and the
// MEM stage. Arbitrates, runs the IDLE/BUSY/DONE FSM, handles branch flush,
// and returns a one-cycle ready pulse to the requester that owned the access.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   if_read, if_addr             fetch request (always 4 bytes)
//   if_ready, if_data            fetch completion pulse and instruction
//   flush                        abort pending / in-flight fetch
//   mem_read, mem_write,         load/store request, address, length,
//   mem_addr, mem_len, mem_wdata store data
//   mem_ready, mem_rdata         load/store completion pulse, zero-extended load data
//   ram_addr, ram_we, ram_dout,  RAM port (read data valid one cycle after address)
//   ram_din
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int IF_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_read,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              flush,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    mc_state_t         state, state_next;
    owner_t            owner, pick;
    logic              if_req, mem_req;
    logic              start;
    logic [ADDR_W-1:0] seq_base;
    logic [2:0]        seq_n;
    logic              seq_wr;
    logic              seq_last;
    logic [31:0]       seq_rdata;
    logic [31:0]       if_hold, mem_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= MC_IDLE;
            owner    <= OWN_IF;
            if_hold  <= '0;
            mem_hold <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                owner <= pick;
            end
            if (if_ready) begin
                if_hold <= seq_rdata;
            end
            if (mem_ready) begin
                mem_hold <= seq_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        if_req     = if_read && !flush;
        mem_req    = mem_read || mem_write;
        pick       = (mem_req && (!if_req || IF_PRIO == 0)) ? OWN_MEM : OWN_IF;
        seq_base   = (pick == OWN_MEM) ? mem_addr : if_addr;
        seq_n      = (pick == OWN_MEM) ? len_bytes(mem_len) : WORD_BYTES;
        seq_wr     = (pick == OWN_MEM) && mem_write;

        case (state)
            MC_IDLE: begin
                if (if_req || mem_req) begin
                    start      = 1'b1;
                    state_next = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (owner == OWN_IF && flush) begin
                    state_next = MC_IDLE;
                end else if (seq_last) begin
                    state_next = MC_DONE;
                end
            end
            MC_DONE: state_next = MC_IDLE;
            default: state_next = MC_IDLE;
        endcase
    end

    // Flush during an IF-owned DONE suppresses the pulse combinationally.
    assign if_ready  = (state == MC_DONE) && (owner == OWN_IF) && !flush;
    assign mem_ready = (state == MC_DONE) && (owner == OWN_MEM);
    assign if_data   = if_ready  ? seq_rdata : if_hold;
    assign mem_rdata = mem_ready ? seq_rdata : mem_hold;

    mem_byte_seq #(
        .ADDR_W(ADDR_W)
    ) u_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .base     (seq_base),
        .nbytes   (seq_n),
        .wr       (seq_wr),
        .wdata    (mem_wdata),
        .active   (state == MC_BUSY),
        .last     (seq_last),
        .rdata    (seq_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: behavioural RAM, shadow memory reference model,
// directed scenarios plus randomized loads/stores/fetches.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_read;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_ctrl #(
        .ADDR_W (32),
        .IF_PRIO(0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_read  (if_read),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_data  (if_data),
        .flush    (flush),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_len  (mem_len),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    // ---------------- RAM environment (64 KiB alias of the address space)
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'hA5;
    endfunction

    logic [7:0] ram    [0:65535];
    bit         ram_wr [0:65535];

    always @(posedge clk) begin
        ram_din <= ram_wr[ram_addr[15:0]] ? ram[ram_addr[15:0]] : init_byte(ram_addr[15:0]);
        if (ram_we) begin
            ram[ram_addr[15:0]]    <= ram_dout;
            ram_wr[ram_addr[15:0]] <= 1'b1;
        end
    end

    // ---------------- reference model: shadow memory of what RAM should hold
    logic [7:0] ref_mem [0:65535];
    bit         ref_wr  [0:65535];

    function automatic int nbytes(input bit use_if, input logic [1:0] len);
        if (use_if) return 4;
        if (len == 2'd0) return 1;
        if (len == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_wr[a[15:0]] ? ref_mem[a[15:0]] : init_byte(a[15:0]);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = v | (32'(ref_byte(addr + 32'(i))) << (8 * i));
        end
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            ref_mem[a[15:0]] = 8'(wdata >> (8 * i));
            ref_wr[a[15:0]]  = 1'b1;
        end
    endtask

    // Drives one request from an IDLE negedge, observes the RAM bus and the
    // ready pulse, and returns in the following IDLE cycle (at a negedge).
    // lat = number of rising edges from the sampling edge (inclusive) to ready.
    task automatic run_access(input bit use_if, input bit wr, input logic [31:0] addr,
                              input logic [1:0] len, input logic [31:0] wdata,
                              output logic [31:0] data, output int lat, output bit bus_ok);
        int          n;
        logic [31:0] exp_a;
        logic [7:0]  exp_d;
        bit          rdy;
        n      = nbytes(use_if, len);
        data   = '0;
        lat    = 0;
        bus_ok = 1'b1;
        if (use_if) begin
            if_addr = addr;
            if_read = 1'b1;
        end else begin
            mem_addr  = addr;
            mem_len   = len;
            mem_wdata = wdata;
            mem_read  = !wr;
            mem_write = wr;
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= n) begin
                exp_a = addr + 32'(k - 1);
                exp_d = 8'(wdata >> (8 * (k - 1)));
                if (ram_addr !== exp_a || ram_we !== wr || (wr && ram_dout !== exp_d)) bus_ok = 1'b0;
            end
            rdy = use_if ? if_ready : mem_ready;
            if (rdy) begin
                lat  = k;
                data = use_if ? if_data : mem_rdata;
                break;
            end
        end
        if_read   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        bit quiet;
        #3;
        n_checks++;
        if ({if_ready, mem_ready, ram_we, ram_addr, ram_dout, if_data, mem_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got if_rdy=%b mem_rdy=%b we=%b addr=%h required all 0",
                     if_ready, mem_ready, ram_we, ram_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        if_addr = 32'h104;
        if_read = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (ram_addr !== 32'h105) begin
            n_fail++;
            $display("FAIL reset_pre_busy: ram_addr=%h required 00000105", ram_addr);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({if_ready, mem_ready, ram_we, ram_addr, ram_dout, if_data, mem_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got we=%b addr=%h dout=%h required all 0",
                     ram_we, ram_addr, ram_dout);
        end
        if_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_ready !== 1'b0 || mem_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL reset_release_quiet: activity seen after reset, required none");
        end
    endtask

    task automatic test_store_half();
        logic [31:0] d;
        int          lat;
        bit          ok;
        run_access(1'b0, 1'b1, 32'h204, 2'b01, 32'h1234_BEEF, d, lat, ok);
        ref_write(32'h204, 2, 32'h1234_BEEF);
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL store_half_latency: got %0d required 3", lat);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL store_half_bus: byte writes not (204,EF),(205,BE)");
        end
        run_access(1'b0, 1'b0, 32'h204, 2'b10, 32'h0, d, lat, ok);
        n_checks++;
        if (d !== ref_read(32'h204, 4)) begin
            n_fail++;
            $display("FAIL store_half_readback: got %h required %h", d, ref_read(32'h204, 4));
        end
    endtask

    task automatic test_if_fetch();
        logic [31:0] d;
        int          lat;
        bit          ok;
        run_access(1'b0, 1'b1, 32'h100, 2'b10, 32'h0010_0513, d, lat, ok);
        ref_write(32'h100, 4, 32'h0010_0513);
        n_checks++;
        if (lat !== 5 || !ok) begin
            n_fail++;
            $display("FAIL store_word: latency %0d bus_ok %0d required 5 and 1", lat, ok);
        end
        run_access(1'b1, 1'b0, 32'h100, 2'b00, 32'h0, d, lat, ok);
        n_checks++;
        if (d !== 32'h0010_0513) begin
            n_fail++;
            $display("FAIL if_fetch_data: got %h required 00100513", d);
        end
        n_checks++;
        if (lat !== 6 || !ok) begin
            n_fail++;
            $display("FAIL if_fetch_timing: latency %0d bus_ok %0d required 6 and 1", lat, ok);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] d;
        int          lat;
        bit          ok;
        run_access(1'b0, 1'b1, 32'h7, 2'b00, 32'hFFFF_FF80, d, lat, ok);
        ref_write(32'h7, 1, 32'hFFFF_FF80);
        run_access(1'b0, 1'b0, 32'h7, 2'b00, 32'h0, d, lat, ok);
        n_checks++;
        if (d !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL load_byte_data: got %h required 00000080", d);
        end
        n_checks++;
        if (lat !== 3 || !ok) begin
            n_fail++;
            $display("FAIL load_byte_timing: latency %0d bus_ok %0d required 3 and 1", lat, ok);
        end
    endtask

    task automatic test_simultaneous();
        int          mk, ik;
        logic [31:0] md, id;
        mk = 0;
        ik = 0;
        md = '0;
        id = '0;
        if_addr  = 32'h100;
        if_read  = 1'b1;
        mem_addr = 32'h7;
        mem_len  = 2'b00;
        mem_read = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ready && mk == 0) begin
                mk       = k;
                md       = mem_rdata;
                mem_read = 1'b0;
            end
            if (if_ready) begin
                ik      = k;
                id      = if_data;
                if_read = 1'b0;
                break;
            end
        end
        if_read  = 1'b0;
        mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mk !== 3 || md !== ref_read(32'h7, 1)) begin
            n_fail++;
            $display("FAIL arb_mem_first: mem ready at %0d data %h required 3 and %h", mk, md, ref_read(32'h7, 1));
        end
        n_checks++;
        if (ik !== 10 || id !== ref_read(32'h100, 4)) begin
            n_fail++;
            $display("FAIL arb_if_second: if ready at %0d data %h required 10 and %h", ik, id, ref_read(32'h100, 4));
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        int          lat;
        bit          ok, quiet;
        // flush in IF BUSY cycle 2
        if_addr = 32'h100;
        if_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ram_addr !== '0 || if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy_idle: ram_addr=%h if_ready=%b required 0 and 0", ram_addr, if_ready);
        end
        flush   = 1'b0;
        if_read = 1'b0;
        quiet   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_ready !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL flush_no_ready: if_ready pulsed after flush, required none");
        end
        run_access(1'b1, 1'b0, 32'h40, 2'b00, 32'h0, d, lat, ok);
        n_checks++;
        if (d !== ref_read(32'h40, 4) || lat !== 6 || !ok) begin
            n_fail++;
            $display("FAIL flush_refetch: data %h lat %0d bus %0d required %h 6 1", d, lat, ok, ref_read(32'h40, 4));
        end
        // flush together with a new fetch in IDLE masks it
        if_addr = 32'h40;
        if_read = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ram_addr !== '0) begin
            n_fail++;
            $display("FAIL flush_idle_mask: ram_addr=%h required 00000000", ram_addr);
        end
        flush = 1'b0;
        run_access(1'b1, 1'b0, 32'h40, 2'b00, 32'h0, d, lat, ok);
        n_checks++;
        if (lat !== 6 || d !== ref_read(32'h40, 4)) begin
            n_fail++;
            $display("FAIL flush_idle_retry: lat %0d data %h required 6 %h", lat, d, ref_read(32'h40, 4));
        end
        // flush in IF-owned DONE drops the pulse
        if_addr = 32'h100;
        if_read = 1'b1;
        lat     = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_ready) begin
                lat = k;
                break;
            end
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (lat !== 6 || if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: ready seen at %0d, if_ready under flush=%b required 6 and 0", lat, if_ready);
        end
        if_read = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        // flush never touches MEM accesses
        flush = 1'b1;
        run_access(1'b0, 1'b0, 32'h100, 2'b11, 32'h0, d, lat, ok);
        flush = 1'b0;
        n_checks++;
        if (lat !== 6 || d !== ref_read(32'h100, 4) || !ok) begin
            n_fail++;
            $display("FAIL flush_mem_unaffected: lat %0d data %h bus %0d required 6 %h 1", lat, d, ok, ref_read(32'h100, 4));
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, d, exp;
        logic [1:0]  len;
        int          kind, n, lat, exp_lat;
        bit          use_if, wr, ok;
        for (int i = 0; i < 60; i++) begin
            kind   = $urandom_range(0, 2);
            len    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else addr = 32'h3000 + 32'($urandom_range(0, 63));
            wdata   = $urandom;
            use_if  = (kind == 0);
            wr      = (kind == 2);
            n       = nbytes(use_if, len);
            exp     = wr ? 32'h0 : ref_read(addr, n);
            exp_lat = wr ? n + 1 : n + 2;
            run_access(use_if, wr, addr, len, wdata, d, lat, ok);
            if (wr) ref_write(addr, n, wdata);
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: addr %h n %0d wr %0d got %0d required %0d", i, addr, n, wr, lat, exp_lat);
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand_bus[%0d]: addr %h n %0d wr %0d byte sequence wrong", i, addr, n, wr);
            end
            if (!wr) begin
                n_checks++;
                if (d !== exp) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: addr %h n %0d if %0d got %h required %h", i, addr, n, use_if, d, exp);
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        if_read   = 1'b0;
        if_addr   = '0;
        flush     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_len   = '0;
        mem_wdata = '0;
        test_reset();
        test_store_half();
        test_if_fetch();
        test_load_byte();
        test_simultaneous();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
